// File: rtl/eu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : eu_share_arbiter
//  Purpose  : Round-robin sharing of one fixed-latency exponential unit among
//             N requesters, with a tag pipeline that routes results back.
//  Revision : 1.0  initial release
// ============================================================================
module eu_share_arbiter #(
    parameter int N      = 2,
    parameter int W      = 32,
    parameter int Q      = 26,
    parameter int EU_LAT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N-1:0]     req_valid,
    input  logic [N*W-1:0]   req_x,
    output logic [N-1:0]     req_ready,
    output logic             eu_valid_in,
    output logic [W-1:0]     eu_x,
    input  logic [W-1:0]     eu_out,
    output logic [N-1:0]     rsp_valid,
    output logic [W-1:0]     rsp_data,
    output logic             idle
);

    localparam int             c_IDW  = (N > 1) ? $clog2(N) : 1;
    localparam logic [N-1:0]   c_LSB  = N'(1);
    localparam logic [c_IDW-1:0] c_LAST = c_IDW'(N - 1);

    generate
        if (N < 2 || N > 8 || EU_LAT < 1 || Q < 1 || Q >= W) begin : g_param_check
            $error("eu_share_arbiter: unsupported parameter set");
        end
    endgenerate

    logic [c_IDW-1:0] r_rr_ptr;
    logic [EU_LAT:0]  r_tag_v;
    logic [c_IDW-1:0] r_tag_id [EU_LAT+1];
    logic [W-1:0]     r_eu_x;

    logic [N-1:0]     w_upper;
    logic [N-1:0]     w_cand;
    logic [N-1:0]     w_onehot;
    logic [c_IDW-1:0] w_win;
    logic [W-1:0]     w_x;
    logic             w_hs;

    // Lanes at or above rr_ptr take priority; otherwise wrap to the lowest
    // valid lane. Isolating the lowest set bit yields the one-hot winner.
    always_comb begin
        w_upper  = req_valid & ~((c_LSB << r_rr_ptr) - c_LSB);
        w_cand   = (|w_upper) ? w_upper : req_valid;
        w_onehot = w_cand & (~w_cand + c_LSB);
    end

    always_comb begin
        w_win = '0;
        w_x   = '0;
        for (int i = 0; i < N; i++) begin
            if (w_onehot[i]) begin
                w_win = c_IDW'(i);
                w_x   = req_x[i*W +: W];
            end
        end
    end

    assign req_ready = (en && rst_n) ? w_onehot : '0;
    assign w_hs      = |req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
            r_eu_x   <= '0;
            r_tag_v  <= '0;
            for (int i = 0; i <= EU_LAT; i++) begin
                r_tag_id[i] <= '0;
            end
        end else begin
            r_tag_v     <= {r_tag_v[EU_LAT-1:0], w_hs};
            r_tag_id[0] <= w_win;
            for (int i = 1; i <= EU_LAT; i++) begin
                r_tag_id[i] <= r_tag_id[i-1];
            end
            if (w_hs) begin
                r_eu_x   <= w_x;
                r_rr_ptr <= (w_win == c_LAST) ? '0 : w_win + c_IDW'(1);
            end
        end
    end

    // Stage 0 of the tag pipeline doubles as the EU issue strobe.
    assign eu_valid_in = r_tag_v[0];
    assign eu_x        = r_eu_x;

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < N; i++) begin
            if (r_tag_v[EU_LAT] && (r_tag_id[EU_LAT] == c_IDW'(i))) begin
                rsp_valid[i] = 1'b1;
            end
        end
    end

    assign rsp_data = eu_out;
    assign idle     = ~|r_tag_v;

endmodule
`default_nettype wire

// File: tb/tb_eu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_eu_share_arbiter
//  Purpose  : Self-checking bench for eu_share_arbiter with an EU stand-in.
//  Revision : 1.0  initial release
// ============================================================================
module tb_eu_share_arbiter;

    localparam int          N      = 2;
    localparam int          W      = 32;
    localparam int          EU_LAT = 4;
    localparam logic [31:0] C_EU   = 32'h0400_0000;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_x = '0;
    logic [N-1:0]   req_ready;
    logic           eu_valid_in;
    logic [W-1:0]   eu_x;
    logic [W-1:0]   eu_out;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic           idle;

    eu_share_arbiter #(.N(N), .W(W), .Q(26), .EU_LAT(EU_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_x(req_x),
        .req_ready(req_ready), .eu_valid_in(eu_valid_in), .eu_x(eu_x),
        .eu_out(eu_out), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .idle(idle)
    );

    always #5 clk = ~clk;

    // EU stand-in: result of an operand presented in cycle t+1 is on eu_out in t+1+EU_LAT.
    logic [W-1:0] eu_pipe [EU_LAT];
    always @(posedge clk) begin
        eu_pipe[0] <= eu_x;
        for (int k = 1; k < EU_LAT; k++) eu_pipe[k] <= eu_pipe[k-1];
    end
    assign eu_out = eu_pipe[EU_LAT-1] + C_EU;

    // Reference model: list of outstanding ops with their due cycle.
    typedef struct {
        int         due;
        int         lane;
        logic [W-1:0] res;
    } op_t;
    op_t        pend[$];
    int         rr_m = 0;
    int         cyc = 0;
    int         last_issue = -100;
    logic [W-1:0] last_x = '0;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        logic         e;
        logic [1:0]   v;
        logic [31:0]  x0;
        logic [31:0]  x1;
        logic [1:0]   rdy;
        logic [1:0]   rsp;
        logic         dchk;
        logic [31:0]  data;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic add(input logic e, input logic [1:0] v, input logic [31:0] x0,
                       input logic [31:0] x1, input logic [1:0] rdy, input logic [1:0] rsp,
                       input logic dchk, input logic [31:0] data);
        vec_t r;
        r.e = e; r.v = v; r.x0 = x0; r.x1 = x1; r.rdy = rdy; r.rsp = rsp;
        r.dchk = dchk; r.data = data;
        tbl.push_back(r);
    endtask

    // One clock cycle: drive inputs after the falling edge, compare against the
    // model, advance the model, then wait for the next falling edge.
    task automatic step(input logic e, input logic [N-1:0] v, input logic [W-1:0] x0,
                        input logic [W-1:0] x1, output logic [N-1:0] o_rdy,
                        output logic [N-1:0] o_rsp, output logic [W-1:0] o_data,
                        output logic o_idle);
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_rsp;
        logic [W-1:0] exp_data;
        logic [W-1:0] wx;
        int           win;
        bit           busy;
        en = e; req_valid = v; req_x = {x1, x0};
        #1;
        win = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (rr_m + k) % N;
            if (win < 0 && v[i]) win = i;
        end
        exp_rdy = '0;
        if (e && win >= 0) exp_rdy[win] = 1'b1;
        while (pend.size() > 0 && pend[0].due < cyc) void'(pend.pop_front());
        exp_rsp = '0; exp_data = '0; busy = 0;
        foreach (pend[j]) begin
            busy = 1;
            if (pend[j].due == cyc) begin
                exp_rsp[pend[j].lane] = 1'b1;
                exp_data = pend[j].res;
            end
        end
        o_rdy = req_ready; o_rsp = rsp_valid; o_data = rsp_data; o_idle = idle;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
        if (|exp_rsp) chk("rsp_data", rsp_data, exp_data);
        chk("eu_valid_in", 32'(eu_valid_in), 32'(last_issue == cyc - 1));
        chk("eu_x", eu_x, last_x);
        chk("idle", 32'(idle), 32'(!busy));
        if (exp_rdy != '0) begin
            wx = (win == 0) ? x0 : x1;
            pend.push_back('{cyc + 1 + EU_LAT, win, wx + C_EU});
            last_issue = cyc;
            last_x = wx;
            rr_m = (win + 1) % N;
        end
        @(negedge clk);
        cyc++;
    endtask

    logic [N-1:0] s_rdy, s_rsp;
    logic [W-1:0] s_data;
    logic         s_idle;
    int           nrsp;

    initial begin
        // Directed vectors: single op, alternating pair, lone lane1 stream.
        add(1, 2'b01, 32'h0A00_0000, 32'h0, 2'b01, 2'b00, 0, 32'h0);
        for (int k = 1; k <= 4; k++) add(1, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);
        add(1, 2'b00, 0, 0, 2'b00, 2'b01, 1, 32'h0E00_0000);
        add(1, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);
        for (int k = 0; k < 6; k++)
            add(1, 2'b11, 32'(k), 32'h100 + 32'(k), (k % 2 == 0) ? 2'b10 : 2'b01,
                (k == 5) ? 2'b10 : 2'b00, (k == 5), 32'h0400_0100);
        for (int k = 1; k <= 5; k++)
            add(1, 2'b00, 0, 0, 2'b00, (k % 2 == 1) ? 2'b01 : 2'b10, 0, 0);
        for (int k = 0; k < 5; k++)
            add(1, 2'b10, 0, 32'h200 + 32'(k), 2'b10, 2'b00, 0, 0);
        for (int k = 0; k < 5; k++) add(1, 2'b00, 0, 0, 2'b00, 2'b10, 0, 0);
        add(1, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);

        // Reset state with requests pending: nothing may be granted or issued.
        en = 1'b1; req_valid = 2'b11; req_x = {32'h1, 32'h2};
        #3;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_eu_valid", 32'(eu_valid_in), 32'h0);
        chk("rst_eu_x", eu_x, 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_idle", 32'(idle), 32'h1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[r]) begin
            step(tbl[r].e, tbl[r].v, tbl[r].x0, tbl[r].x1, s_rdy, s_rsp, s_data, s_idle);
            chk($sformatf("tbl%0d_ready", r), 32'(s_rdy), 32'(tbl[r].rdy));
            chk($sformatf("tbl%0d_rsp", r), 32'(s_rsp), 32'(tbl[r].rsp));
            if (tbl[r].dchk) chk($sformatf("tbl%0d_data", r), s_data, tbl[r].data);
        end

        // en drops after two grants of a burst: only two results come back.
        step(1, 2'b11, 32'h11, 32'h22, s_rdy, s_rsp, s_data, s_idle);
        step(1, 2'b11, 32'h33, 32'h44, s_rdy, s_rsp, s_data, s_idle);
        nrsp = 0;
        for (int k = 0; k < 7; k++) begin
            step(0, 2'b11, 32'h55, 32'h66, s_rdy, s_rsp, s_data, s_idle);
            chk("en0_ready", 32'(s_rdy), 32'h0);
            nrsp += $countones(s_rsp);
        end
        chk("en0_rsp_count", 32'(nrsp), 32'd2);
        chk("en0_idle", 32'(s_idle), 32'h1);
        step(1, 2'b11, 32'h77, 32'h88, s_rdy, s_rsp, s_data, s_idle);
        chk("en1_resume", 32'(s_rdy), 32'h1);

        // Asynchronous reset with ops in flight.
        step(1, 2'b11, 32'h91, 32'h92, s_rdy, s_rsp, s_data, s_idle);
        step(1, 2'b11, 32'h93, 32'h94, s_rdy, s_rsp, s_data, s_idle);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req_ready", 32'(req_ready), 32'h0);
        chk("arst_eu_valid", 32'(eu_valid_in), 32'h0);
        chk("arst_eu_x", eu_x, 32'h0);
        chk("arst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("arst_idle", 32'(idle), 32'h1);
        pend.delete();
        rr_m = 0; last_issue = -100; last_x = '0;
        @(negedge clk);
        @(negedge clk);
        cyc += 2;
        rst_n = 1'b1;
        for (int k = 0; k < 7; k++)
            step(1, 2'b00, 0, 0, s_rdy, s_rsp, s_data, s_idle);
        step(1, 2'b11, 32'hA1, 32'hA2, s_rdy, s_rsp, s_data, s_idle);
        chk("post_rst_rr0", 32'(s_rdy), 32'h1);
        for (int k = 0; k < 7; k++)
            step(1, 2'b00, 0, 0, s_rdy, s_rsp, s_data, s_idle);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++)
            step($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), $urandom, $urandom,
                 s_rdy, s_rsp, s_data, s_idle);
        for (int k = 0; k < 7; k++)
            step(1, 2'b00, 0, 0, s_rdy, s_rsp, s_data, s_idle);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
